// File: rtl/keypad_scanner_if.sv
//----------------------------------------------------------------------------
// Module  : keypad_scanner_if
// Brief   : Debounced keystroke level/code bundle from scanner to control FSMs
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
//----------------------------------------------------------------------------
// Module  : keypad_scanner
// Brief   : 4x4 active-low matrix keypad scanner with press/release debounce
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [3:0]   row_in,
    output logic [3:0]        col_out,
    keypad_scanner_if.master  key_if
);

    localparam int c_scan_w = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
    localparam int c_deb_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    // Transition fires on the sample that would bring the count to DEBOUNCE_CYCLES-1
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        S_SCAN        = 2'd0,
        S_DEB_PRESS   = 2'd1,
        S_PRESSED     = 2'd2,
        S_DEB_RELEASE = 2'd3
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_s;
    logic [1:0]          r_col_idx,   w_col_idx_nxt;
    logic [c_scan_w-1:0] r_scan_cnt,  w_scan_cnt_nxt;
    logic [c_deb_w-1:0]  r_deb_cnt,   w_deb_cnt_nxt;
    logic [3:0]          r_row_pat,   w_row_pat_nxt;
    logic [1:0]          r_row_idx,   w_row_idx_nxt;
    logic                r_key_valid, w_key_valid_nxt;
    logic [3:0]          r_key_code,  w_key_code_nxt;
    logic [3:0]          w_low;
    logic                w_one_low;
    logic [1:0]          w_row_enc;

    function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;  4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;  4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;  4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;  4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;  4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;  4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;  4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;  default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_s    <= r_row_meta;
        end
    end

    assign w_low     = ~r_row_s;
    assign w_one_low = (w_low != 4'h0) && ((w_low & (w_low - 4'd1)) == 4'h0);

    always_comb begin
        w_row_enc = 2'd0;
        case (r_row_s)
            4'b1101: w_row_enc = 2'd1;
            4'b1011: w_row_enc = 2'd2;
            4'b0111: w_row_enc = 2'd3;
            default: w_row_enc = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_col_idx   <= 2'd0;
            r_scan_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_row_pat   <= 4'hF;
            r_row_idx   <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_scan_cnt  <= w_scan_cnt_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_row_pat   <= w_row_pat_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_scan_cnt_nxt  = r_scan_cnt;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_row_pat_nxt   = r_row_pat;
        w_row_idx_nxt   = r_row_idx;
        w_key_valid_nxt = r_key_valid;
        w_key_code_nxt  = r_key_code;

        case (r_state)
            S_SCAN: begin
                if (r_scan_cnt == c_scan_last) begin
                    w_scan_cnt_nxt = '0;
                    if (w_one_low) begin
                        w_row_pat_nxt = r_row_s;
                        w_row_idx_nxt = w_row_enc;
                        w_deb_cnt_nxt = '0;
                        w_state_nxt   = S_DEB_PRESS;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end else begin
                    w_scan_cnt_nxt = r_scan_cnt + 1'b1;
                end
            end
            S_DEB_PRESS: begin
                if (r_row_s != r_row_pat) begin
                    w_state_nxt   = S_SCAN;
                    w_col_idx_nxt = r_col_idx + 2'd1;
                end else if (r_deb_cnt == c_deb_last) begin
                    w_state_nxt     = S_PRESSED;
                    w_key_valid_nxt = 1'b1;
                    w_key_code_nxt  = decode_key(r_row_idx, r_col_idx);
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                // Only a full release matters; extra keys in other rows are ignored
                if (r_row_s == 4'hF) begin
                    w_deb_cnt_nxt = '0;
                    w_state_nxt   = S_DEB_RELEASE;
                end
            end
            S_DEB_RELEASE: begin
                if (r_row_s != 4'hF) begin
                    w_state_nxt = S_PRESSED;
                end else if (r_deb_cnt == c_deb_last) begin
                    w_state_nxt     = S_SCAN;
                    w_key_valid_nxt = 1'b0;
                    w_col_idx_nxt   = r_col_idx + 2'd1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_SCAN;
        endcase
    end

    assign col_out          = ~(4'b0001 << r_col_idx);
    assign key_if.key_valid = r_key_valid;
    assign key_if.key_code  = r_key_code;

endmodule

`default_nettype wire
